axis_hdr_arbiter: RTL and testbench
===================================

# axis_hdr_arbiter

Packet-level scheduler sharing a single `axi_stream_insert_header` datapath among NUM_SRC requesters. Each requester presents a header (data, keep, byte count) plus its payload AXI Stream. The arbiter grants one source at a time, forwards its header to the insert port, then its payload up to and including `last`, then re-arbitrates. It sits directly upstream of the header-insert block, so that block never sees interleaved packets or headers.

## Interface
Parameters:
- DATA_WD, 32, payload/header width in bits
- DATA_BYTE_WD, DATA_WD/8, keep width
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), header byte-count width
- NUM_SRC, 4, number of requesters (2..16)
- SRC_WD, ($clog2(NUM_SRC) > 0 ? $clog2(NUM_SRC) : 1), grant index width

Ports (source i occupies slice [i*W +: W] of each flattened bus):
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_hdr_valid  in  NUM_SRC  per-source header valid
- s_hdr_data  in  NUM_SRC*DATA_WD  headers
- s_hdr_keep  in  NUM_SRC*DATA_BYTE_WD  header keeps
- s_hdr_cnt  in  NUM_SRC*BYTE_CNT_WD  header byte counts
- s_hdr_ready  out  NUM_SRC  header accepted
- s_valid  in  NUM_SRC  payload valid
- s_data  in  NUM_SRC*DATA_WD  payload data
- s_keep  in  NUM_SRC*DATA_BYTE_WD  payload keep
- s_last  in  NUM_SRC  payload last
- s_ready  out  NUM_SRC  payload ready
- valid_insert, data_insert, keep_insert, byte_insert_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD  to insert block
- ready_insert  in  1  from insert block
- valid_in, data_in, keep_in, last_in  out  1/DATA_WD/DATA_BYTE_WD/1  to insert block
- ready_in  in  1  from insert block
- busy  out  1  state != IDLE
- grant_id  out  SRC_WD  currently granted source

## Operation
- States: IDLE, HDR, DATA (2-bit, registered).
- IDLE: if any s_hdr_valid bit is set, pick the winner, register grant_id, go to HDR. Otherwise stay.
- HDR: valid_insert = s_hdr_valid[grant_id]; the insert bus muxes the granted slice; s_hdr_ready[grant_id] = ready_insert. On the header handshake go to DATA.
- DATA: valid_in = s_valid[grant_id]; data, keep and last are muxed from the grant; s_ready[grant_id] = ready_in. On a handshake with s_last set, go to IDLE and set rr_ptr = grant_id + 1, wrapping modulo NUM_SRC.
- Round-robin: search starts at rr_ptr and takes the first set request in ascending order, wrapping.
- Ungranted sources see ready = 0. Payload presented before its header is granted is held, not dropped.
- valid_insert = 0 outside HDR. valid_in = 0 outside DATA.
- No payload is accepted in HDR. No header is accepted in DATA.
- A requester dropping s_hdr_valid while granted in HDR is a protocol violation. The FSM stays in HDR and never re-arbitrates spontaneously.
- Single-beat packet (last on the first beat): DATA lasts one handshake cycle.

## Timing
- Reset values: state = IDLE, grant_id = 0, rr_ptr = 0, busy = 0. All valid and ready outputs are 0; muxed data/keep/cnt outputs follow grant 0 gated to 0.
- Request to valid_insert: 1 cycle (registered grant).
- Header handshake at cycle t: valid_in may assert at t+1.
- Last-beat handshake at cycle t: IDLE at t+1; the next grant is registered at t+1; the next valid_insert is at t+2. Minimum gap between packets is 2 cycles.
- All outputs are combinational from registered state/grant plus the muxed inputs. No combinational path from ready_insert/ready_in into valid outputs.
- Reset mid-packet: immediate return to IDLE. The partial packet is abandoned; the upstream source is responsible for it.

## Configuration
- AXIS_HDR_ARB_PRIO_EN defined: source 0 has strict priority. Whenever s_hdr_valid[0] is set in IDLE it wins. The other sources use round-robin among themselves, and rr_ptr ignores grants to source 0.
- Undefined: pure round-robin across all NUM_SRC sources.
- Ports are identical in both builds.

## Structure
- Package axis_hdr_pkg: FSM state encoding localparams (ST_IDLE = 0, ST_HDR = 1, ST_DATA = 2) and the DATA_WD/NUM_SRC defaults, shared with the insert block's bench.
- Sub-module axis_rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_SRC-1:0], ptr[SRC_WD-1:0].
  - Outputs: gnt_id, gnt_vld.
  - The prio variant wraps this picker.

## Test plan
- Single source: src1 header 0xAABBCCDD, cnt 2, then a 3-beat payload with last on beat 3. Expect grant_id = 1, valid_insert 1 cycle after the request, 1 insert handshake, 3 valid_in beats with last_in on the 3rd, busy = 0 afterwards.
- All 4 sources requesting continuously, 1-beat packets each. Grant order 0,1,2,3,0; 2-cycle gap between packets; no s_ready asserted to an ungranted source.
- Backpressure: ready_in toggles 1,0,0,1 during a 4-beat src2 packet. Data is held stable while stalled, no beat is duplicated, and the FSM leaves DATA only on the last handshake.
- Payload before header: src3 asserts s_valid 5 cycles before s_hdr_valid. s_ready[3] stays 0 until DATA.
- Reset asserted mid-DATA on beat 2 of src0. Next cycle: busy = 0, all valid outputs 0, grant_id = 0. After release, a fresh src0 request is served normally.
- With AXIS_HDR_ARB_PRIO_EN: src0 and src2 request together repeatedly. src0 wins every arbitration.

Source files
------------

// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the header-insert arbiter: FSM encoding, bus defaults and
// the wrapping pointer helper.
package axis_hdr_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StHdr  = ST_HDR,
        StData = ST_DATA
    } state_e;

    localparam int unsigned DEF_DATA_WD = 32;
    localparam int unsigned DEF_NUM_SRC = 4;

    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
    endfunction

endpackage

// File: rtl/axis_hdr_arbiter_if.sv
// Bundle of the per-source request buses and the two insert-block ports.
// master: the arbiter; slave: requesters plus insert block as seen from outside.
interface axis_hdr_arbiter_if import axis_hdr_pkg::*; #(
    parameter int unsigned DATA_WD      = DEF_DATA_WD,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned NUM_SRC      = DEF_NUM_SRC
);

    logic [NUM_SRC-1:0]              s_hdr_valid;
    logic [NUM_SRC*DATA_WD-1:0]      s_hdr_data;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] s_hdr_keep;
    logic [NUM_SRC*BYTE_CNT_WD-1:0]  s_hdr_cnt;
    logic [NUM_SRC-1:0]              s_hdr_ready;

    logic [NUM_SRC-1:0]              s_valid;
    logic [NUM_SRC*DATA_WD-1:0]      s_data;
    logic [NUM_SRC*DATA_BYTE_WD-1:0] s_keep;
    logic [NUM_SRC-1:0]              s_last;
    logic [NUM_SRC-1:0]              s_ready;

    logic                            valid_insert;
    logic [DATA_WD-1:0]              data_insert;
    logic [DATA_BYTE_WD-1:0]         keep_insert;
    logic [BYTE_CNT_WD-1:0]          byte_insert_cnt;
    logic                            ready_insert;

    logic                            valid_in;
    logic [DATA_WD-1:0]              data_in;
    logic [DATA_BYTE_WD-1:0]         keep_in;
    logic                            last_in;
    logic                            ready_in;

    modport master (
        input  s_hdr_valid, s_hdr_data, s_hdr_keep, s_hdr_cnt,
        output s_hdr_ready,
        input  s_valid, s_data, s_keep, s_last,
        output s_ready,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_insert,
        output valid_in, data_in, keep_in, last_in,
        input  ready_in
    );

    modport slave (
        output s_hdr_valid, s_hdr_data, s_hdr_keep, s_hdr_cnt,
        input  s_hdr_ready,
        output s_valid, s_data, s_keep, s_last,
        input  s_ready,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_insert,
        input  valid_in, data_in, keep_in, last_in,
        output ready_in
    );

endinterface

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, ascending,
// wrapping modulo NUM_SRC.
module axis_rr_pick import axis_hdr_pkg::*; #(
    parameter int unsigned NUM_SRC = DEF_NUM_SRC,
    parameter int unsigned SRC_WD  = ($clog2(NUM_SRC) > 0 ? $clog2(NUM_SRC) : 1)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_WD-1:0]  ptr,
    output logic [SRC_WD-1:0]  gnt_id,
    output logic               gnt_vld
);

    logic [SRC_WD-1:0] idx;

    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = SRC_WD'((32'(ptr) + i) % NUM_SRC);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

endmodule

// File: rtl/axis_hdr_arbiter.sv
// Packet-level scheduler in front of the header-insert block: grants one source,
// passes its header then its payload up to last. AXIS_HDR_ARB_PRIO_EN gives source 0
// strict priority over a round-robin among the rest.
module axis_hdr_arbiter import axis_hdr_pkg::*; #(
    parameter int unsigned DATA_WD      = DEF_DATA_WD,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned NUM_SRC      = DEF_NUM_SRC,
    parameter int unsigned SRC_WD       = ($clog2(NUM_SRC) > 0 ? $clog2(NUM_SRC) : 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axis_hdr_arbiter_if.master        bus,
    output logic                      busy,
    output logic [SRC_WD-1:0]         grant_id
);

    state_e            state_q, state_d;
    logic [SRC_WD-1:0] grant_q, grant_d;
    logic [SRC_WD-1:0] rr_ptr_q, rr_ptr_d;

    // Flattened buses split into per-source arrays so the grant can index them.
    logic [DATA_WD-1:0]      hdr_data_a [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] hdr_keep_a [NUM_SRC];
    logic [BYTE_CNT_WD-1:0]  hdr_cnt_a  [NUM_SRC];
    logic [DATA_WD-1:0]      pay_data_a [NUM_SRC];
    logic [DATA_BYTE_WD-1:0] pay_keep_a [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_slice
        assign hdr_data_a[i] = bus.s_hdr_data[i*DATA_WD +: DATA_WD];
        assign hdr_keep_a[i] = bus.s_hdr_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        assign hdr_cnt_a[i]  = bus.s_hdr_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
        assign pay_data_a[i] = bus.s_data[i*DATA_WD +: DATA_WD];
        assign pay_keep_a[i] = bus.s_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
    end

    logic [NUM_SRC-1:0] pick_req;
    logic [SRC_WD-1:0]  pick_id;
    logic               pick_vld;
    logic [SRC_WD-1:0]  win_id;
    logic               win_vld;
    logic [SRC_WD-1:0]  ptr_next;

    axis_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_WD  (SRC_WD)
    ) u_pick (
        .req     (pick_req),
        .ptr     (rr_ptr_q),
        .gnt_id  (pick_id),
        .gnt_vld (pick_vld)
    );

`ifdef AXIS_HDR_ARB_PRIO_EN
    // Source 0 bypasses the picker; the picker only sees the remaining sources.
    assign pick_req = bus.s_hdr_valid & {{(NUM_SRC-1){1'b1}}, 1'b0};
    assign win_vld  = bus.s_hdr_valid[0] | pick_vld;
    assign win_id   = bus.s_hdr_valid[0] ? '0 : pick_id;
`else
    assign pick_req = bus.s_hdr_valid;
    assign win_vld  = pick_vld;
    assign win_id   = pick_id;
`endif

    assign ptr_next = SRC_WD'(wrap_inc(32'(grant_q), NUM_SRC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        rr_ptr_d             = rr_ptr_q;
        bus.s_hdr_ready      = '0;
        bus.s_ready          = '0;
        bus.valid_insert     = 1'b0;
        bus.data_insert      = '0;
        bus.keep_insert      = '0;
        bus.byte_insert_cnt  = '0;
        bus.valid_in         = 1'b0;
        bus.data_in          = '0;
        bus.keep_in          = '0;
        bus.last_in          = 1'b0;

        case (state_q)
            StIdle: begin
                if (win_vld) begin
                    grant_d = win_id;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                bus.valid_insert         = bus.s_hdr_valid[grant_q];
                bus.data_insert          = hdr_data_a[grant_q];
                bus.keep_insert          = hdr_keep_a[grant_q];
                bus.byte_insert_cnt      = hdr_cnt_a[grant_q];
                bus.s_hdr_ready[grant_q] = bus.ready_insert;
                if (bus.s_hdr_valid[grant_q] && bus.ready_insert) begin
                    state_d = StData;
                end
            end
            StData: begin
                bus.valid_in         = bus.s_valid[grant_q];
                bus.data_in          = pay_data_a[grant_q];
                bus.keep_in          = pay_keep_a[grant_q];
                bus.last_in          = bus.s_last[grant_q];
                bus.s_ready[grant_q] = bus.ready_in;
                if (bus.s_valid[grant_q] && bus.ready_in && bus.s_last[grant_q]) begin
                    state_d = StIdle;
`ifdef AXIS_HDR_ARB_PRIO_EN
                    if (grant_q != '0) begin
                        rr_ptr_d = ptr_next;
                    end
`else
                    rr_ptr_d = ptr_next;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_axis_hdr_arbiter.sv
// Directed-vector bench for axis_hdr_arbiter: per-cycle stimulus/expectation rows
// plus hand-driven reset sequences.
module tb_axis_hdr_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NS = 4;
    localparam int unsigned SW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           busy;
    logic [SW-1:0]  grant_id;

    always #5 clk = ~clk;

    axis_hdr_arbiter_if #(.DATA_WD(DW), .NUM_SRC(NS)) bus ();

    axis_hdr_arbiter #(
        .DATA_WD (DW),
        .NUM_SRC (NS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .grant_id (grant_id)
    );

    typedef struct {
        logic [3:0] hv, sv, sl;
        logic       ri, rin;
        logic [7:0] beat;
        logic       e_vi, e_vin, e_last, e_busy;
        logic [1:0] e_gnt;
        logic [3:0] e_hrdy, e_srdy;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   row   = 0;

    function automatic logic [31:0] hdr_pat(int i);
        return (i == 1) ? 32'hAABBCCDD : {24'h4D5E6F, 8'(i)};
    endfunction

    function automatic logic [31:0] pay_pat(int i, logic [7:0] b);
        return {8'hD0, 8'(i), 8'h00, b};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] hv, sv, sl, input logic ri, rin,
                         input logic [7:0] beat);
        bus.s_hdr_valid  = hv;
        bus.s_valid      = sv;
        bus.s_last       = sl;
        bus.ready_insert = ri;
        bus.ready_in     = rin;
        for (int i = 0; i < 4; i++) begin
            bus.s_hdr_data[i*32 +: 32] = hdr_pat(i);
            bus.s_hdr_keep[i*4 +: 4]   = 4'hF ^ 4'(i);
            bus.s_hdr_cnt[i*2 +: 2]    = 2'(i + 1);
            bus.s_data[i*32 +: 32]     = pay_pat(i, beat);
            bus.s_keep[i*4 +: 4]       = 4'(i + 1);
        end
    endtask

    task automatic add(input logic [3:0] hv, sv, sl, input logic ri, rin, input logic [7:0] beat,
                       input logic e_vi, e_vin, e_last, e_busy, input logic [1:0] e_gnt,
                       input logic [3:0] e_hrdy, e_srdy);
        vec_t v;
        v.hv = hv; v.sv = sv; v.sl = sl; v.ri = ri; v.rin = rin; v.beat = beat;
        v.e_vi = e_vi; v.e_vin = e_vin; v.e_last = e_last; v.e_busy = e_busy;
        v.e_gnt = e_gnt; v.e_hrdy = e_hrdy; v.e_srdy = e_srdy;
        tbl.push_back(v);
    endtask

    // One single-beat packet from g with all sources in req asserting continuously.
    task automatic pkt1(input logic [1:0] prev, g, input logic [3:0] req);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        add(req, req, req, 1, 1, 8'h10 + 8'(g), 0, 0, 0, 0, prev, 4'h0, 4'h0);
        add(req, req, req, 1, 1, 8'h10 + 8'(g), 1, 0, 0, 1, g, oh, 4'h0);
        add(req, req, req, 1, 1, 8'h10 + 8'(g), 0, 1, 1, 1, g, 4'h0, oh);
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        drive(v.hv, v.sv, v.sl, v.ri, v.rin, v.beat);
        #1;
        chk("valid_insert", 32'(bus.valid_insert), 32'(v.e_vi));
        chk("valid_in", 32'(bus.valid_in), 32'(v.e_vin));
        chk("busy", 32'(busy), 32'(v.e_busy));
        chk("grant_id", 32'(grant_id), 32'(v.e_gnt));
        chk("s_hdr_ready", 32'(bus.s_hdr_ready), 32'(v.e_hrdy));
        chk("s_ready", 32'(bus.s_ready), 32'(v.e_srdy));
        if (v.e_vi) begin
            chk("data_insert", bus.data_insert, hdr_pat(int'(v.e_gnt)));
            chk("keep_insert", 32'(bus.keep_insert), 32'(4'hF ^ 4'(v.e_gnt)));
            chk("byte_insert_cnt", 32'(bus.byte_insert_cnt), 32'(2'(v.e_gnt + 2'd1)));
        end
        if (v.e_vin) begin
            chk("data_in", bus.data_in, pay_pat(int'(v.e_gnt), v.beat));
            chk("keep_in", 32'(bus.keep_in), 32'(4'(v.e_gnt) + 4'd1));
            chk("last_in", 32'(bus.last_in), 32'(v.e_last));
        end
        row++;
    endtask

    task automatic run_tbl();
        foreach (tbl[k]) step(tbl[k]);
        tbl.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " grant_id"}, 32'(grant_id), 32'd0);
        chk({tag, " valid_insert"}, 32'(bus.valid_insert), 32'd0);
        chk({tag, " valid_in"}, 32'(bus.valid_in), 32'd0);
        chk({tag, " s_ready"}, 32'(bus.s_ready), 32'd0);
        chk({tag, " s_hdr_ready"}, 32'(bus.s_hdr_ready), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'h00);
        #1;
        chk_idle_outputs("reset");
        chk("reset data_insert", bus.data_insert, 32'd0);
        chk("reset keep_insert", 32'(bus.keep_insert), 32'd0);
        chk("reset byte_insert_cnt", 32'(bus.byte_insert_cnt), 32'd0);
        chk("reset data_in", bus.data_in, 32'd0);
        chk("reset keep_in", 32'(bus.keep_in), 32'd0);
        chk("reset last_in", 32'(bus.last_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single source: src1, header then 3 beats.
        add(4'b0010, 4'h0, 4'h0, 1, 1, 8'h00, 0, 0, 0, 0, 2'd0, 4'h0, 4'h0);
        add(4'b0010, 4'h0, 4'h0, 1, 1, 8'h00, 1, 0, 0, 1, 2'd1, 4'b0010, 4'h0);
        add(4'b0000, 4'b0010, 4'h0, 1, 1, 8'h01, 0, 1, 0, 1, 2'd1, 4'h0, 4'b0010);
        add(4'b0000, 4'b0010, 4'h0, 1, 1, 8'h02, 0, 1, 0, 1, 2'd1, 4'h0, 4'b0010);
        add(4'b0000, 4'b0010, 4'b0010, 1, 1, 8'h03, 0, 1, 1, 1, 2'd1, 4'h0, 4'b0010);
        add(4'b0000, 4'h0, 4'h0, 1, 1, 8'h00, 0, 0, 0, 0, 2'd1, 4'h0, 4'h0);
        run_tbl();

        // All four requesting, single-beat packets: order 0,1,2,3,0.
        do_reset();
        pkt1(2'd0, 2'd0, 4'hF);
        pkt1(2'd0, 2'd1, 4'hF);
        pkt1(2'd1, 2'd2, 4'hF);
        pkt1(2'd2, 2'd3, 4'hF);
        pkt1(2'd3, 2'd0, 4'hF);
        run_tbl();

        // Backpressure on both ports during a 4-beat src2 packet.
        do_reset();
        add(4'b0100, 4'h0, 4'h0, 1, 1, 8'h00, 0, 0, 0, 0, 2'd0, 4'h0, 4'h0);
        add(4'b0100, 4'h0, 4'h0, 0, 1, 8'h00, 1, 0, 0, 1, 2'd2, 4'h0, 4'h0);
        add(4'b0100, 4'h0, 4'h0, 1, 1, 8'h00, 1, 0, 0, 1, 2'd2, 4'b0100, 4'h0);
        add(4'h0, 4'b0100, 4'h0, 1, 1, 8'h01, 0, 1, 0, 1, 2'd2, 4'h0, 4'b0100);
        add(4'h0, 4'b0100, 4'h0, 1, 0, 8'h02, 0, 1, 0, 1, 2'd2, 4'h0, 4'h0);
        add(4'h0, 4'b0100, 4'h0, 1, 0, 8'h02, 0, 1, 0, 1, 2'd2, 4'h0, 4'h0);
        add(4'h0, 4'b0100, 4'h0, 1, 1, 8'h02, 0, 1, 0, 1, 2'd2, 4'h0, 4'b0100);
        add(4'h0, 4'b0100, 4'h0, 1, 1, 8'h03, 0, 1, 0, 1, 2'd2, 4'h0, 4'b0100);
        add(4'h0, 4'b0100, 4'b0100, 1, 0, 8'h04, 0, 1, 1, 1, 2'd2, 4'h0, 4'h0);
        add(4'h0, 4'b0100, 4'b0100, 1, 1, 8'h04, 0, 1, 1, 1, 2'd2, 4'h0, 4'b0100);
        add(4'h0, 4'h0, 4'h0, 1, 1, 8'h00, 0, 0, 0, 0, 2'd2, 4'h0, 4'h0);
        run_tbl();

        // Payload presented 5 cycles ahead of the src3 header is held off.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            add(4'h0, 4'b1000, 4'b1000, 1, 1, 8'h07, 0, 0, 0, 0, 2'd0, 4'h0, 4'h0);
        end
        add(4'b1000, 4'b1000, 4'b1000, 1, 1, 8'h07, 0, 0, 0, 0, 2'd0, 4'h0, 4'h0);
        add(4'b1000, 4'b1000, 4'b1000, 1, 1, 8'h07, 1, 0, 0, 1, 2'd3, 4'b1000, 4'h0);
        add(4'h0, 4'b1000, 4'b1000, 1, 1, 8'h07, 0, 1, 1, 1, 2'd3, 4'h0, 4'b1000);
        add(4'h0, 4'h0, 4'h0, 1, 1, 8'h00, 0, 0, 0, 0, 2'd3, 4'h0, 4'h0);
        run_tbl();

        // Reset on beat 2 of a src0 packet, then a fresh src0 packet.
        do_reset();
        add(4'b0001, 4'h0, 4'h0, 1, 1, 8'h00, 0, 0, 0, 0, 2'd0, 4'h0, 4'h0);
        add(4'b0001, 4'b0001, 4'h0, 1, 1, 8'h01, 1, 0, 0, 1, 2'd0, 4'b0001, 4'h0);
        add(4'h0, 4'b0001, 4'h0, 1, 1, 8'h01, 0, 1, 0, 1, 2'd0, 4'h0, 4'b0001);
        run_tbl();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h0, 4'b0001, 4'h0, 1'b1, 1'b1, 8'h02);
        #1;
        chk_idle_outputs("mid-packet reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 8'h00);
        pkt1(2'd0, 2'd0, 4'b0001);
        add(4'h0, 4'h0, 4'h0, 1, 1, 8'h00, 0, 0, 0, 0, 2'd0, 4'h0, 4'h0);
        run_tbl();

        // src0 and src2 contending.
        do_reset();
`ifdef AXIS_HDR_ARB_PRIO_EN
        pkt1(2'd0, 2'd0, 4'b0101);
        pkt1(2'd0, 2'd0, 4'b0101);
        pkt1(2'd0, 2'd0, 4'b0101);
`else
        pkt1(2'd0, 2'd0, 4'b0101);
        pkt1(2'd0, 2'd2, 4'b0101);
        pkt1(2'd2, 2'd0, 4'b0101);
`endif
        run_tbl();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
